// File: rtl/csr_unit_if.sv
// csr_unit_if: read/write port between the CSR sequencer (master) and the CSR register file (slave).
interface csr_unit_if;
    logic [11:0] csr_address_r;
    logic [31:0] csr_data;
    logic        csr_we;
    logic [11:0] csr_address_wb;
    logic [31:0] csr_wb;

    modport master (
        output csr_address_r,
        input  csr_data,
        output csr_we,
        output csr_address_wb,
        output csr_wb
    );

    modport slave (
        input  csr_address_r,
        output csr_data,
        input  csr_we,
        input  csr_address_wb,
        input  csr_wb
    );
endinterface

// File: rtl/csr_unit.sv
// csr_unit: Zicsr EX/WB sequencer driving the CSR register-file port.
// Define CSR_FWD_EN for the WB->EX bypass; without it same-CSR back-to-back ops stall one cycle.
module csr_unit (
    input  logic        clk,
    input  logic        nrst,
    input  logic        csr_valid,
    input  logic [2:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic        rd_zero,
    input  logic [1:0]  priv,
    input  logic        stall,
    input  logic        flush,
    csr_unit_if.master  rf_port,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        illegal,
    output logic        stall_req
);
    logic        we_q;
    logic        rd_valid_q;
    logic        illegal_q;
    logic [11:0] addr_q;
    logic [31:0] wb_q;
    logic [31:0] rd_q;
    logic        hazard;
    logic [31:0] old_val;
    logic [31:0] operand;
    logic [31:0] new_val;
    logic        write_intent;
    logic        illegal_ex;
    logic        capture;

    assign rf_port.csr_address_r = csr_addr;
    assign hazard = we_q && (addr_q == csr_addr);

`ifdef CSR_FWD_EN
    assign old_val   = hazard ? wb_q : rf_port.csr_data;
    assign stall_req = 1'b0;
`else
    // Register file commits the WB write only at the end of this cycle, so hold EX once.
    assign old_val   = rf_port.csr_data;
    assign stall_req = csr_valid && hazard;
`endif

    always_comb begin
        operand      = csr_op[2] ? {27'd0, zimm} : rs1_data;
        // zimm carries the rs1 index for register forms, so one test covers both
        write_intent = (csr_op[1:0] == 2'b01) || (zimm != 5'd0);
        case (csr_op[1:0])
            2'b10:   new_val = old_val | operand;
            2'b11:   new_val = old_val & ~operand;
            default: new_val = operand;
        endcase
        illegal_ex = (csr_addr[9:8] > priv) ||
                     (write_intent && (csr_addr[11:10] == 2'b11));
        capture    = csr_valid && !stall && !flush && !stall_req;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            we_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            addr_q     <= 12'd0;
            wb_q       <= 32'd0;
            rd_q       <= 32'd0;
        end else begin
            we_q       <= capture && write_intent && !illegal_ex;
            rd_valid_q <= capture && !illegal_ex && !rd_zero;
            illegal_q  <= capture && illegal_ex;
            if (capture) begin
                addr_q <= csr_addr;
                wb_q   <= new_val;
                rd_q   <= old_val;
            end
        end
    end

    assign rf_port.csr_we         = we_q;
    assign rf_port.csr_address_wb = addr_q;
    assign rf_port.csr_wb         = wb_q;
    assign rd_data                = rd_q;
    assign rd_valid               = rd_valid_q;
    assign illegal                = illegal_q;
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: vector table, hand-written corner sequences and random stimulus for csr_unit.
// Honours CSR_FWD_EN the same way as the design (stall_req expectations differ).
module tb_csr_unit;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        csr_valid = 1'b0;
    logic [2:0]  csr_op = 3'b001;
    logic [11:0] csr_addr = 12'h000;
    logic [31:0] rs1_data = 32'd0;
    logic [4:0]  zimm = 5'd0;
    logic        rd_zero = 1'b0;
    logic [1:0]  priv = 2'b11;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        illegal;
    logic        stall_req;

    csr_unit_if bus ();

    csr_unit dut (
        .clk       (clk),
        .nrst      (nrst),
        .csr_valid (csr_valid),
        .csr_op    (csr_op),
        .csr_addr  (csr_addr),
        .rs1_data  (rs1_data),
        .zimm      (zimm),
        .rd_zero   (rd_zero),
        .priv      (priv),
        .stall     (stall),
        .flush     (flush),
        .rf_port   (bus.master),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .illegal   (illegal),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

`ifdef CSR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Register file environment: combinational read, write at clock edge, preload port.
    logic [31:0] rf_mem [4096];
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = 12'd0;
    logic [31:0] pre_val = 32'd0;
    assign bus.csr_data = rf_mem[bus.csr_address_r];
    always @(posedge clk) begin
        if (bus.csr_we) rf_mem[bus.csr_address_wb] <= bus.csr_wb;
        if (pre_en) rf_mem[pre_addr] <= pre_val;
    end

    // Architectural CSR contents as the instruction stream should leave them.
    logic [31:0] mref [4096];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic preset(input logic [11:0] a, input logic [31:0] v);
        @(negedge clk);
        csr_valid = 1'b0;
        pre_en = 1'b1;
        pre_addr = a;
        pre_val = v;
        mref[a] = v;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic drive(input logic [2:0] op, input logic [11:0] a, input logic [31:0] r,
                         input logic [4:0] z, input logic rz, input logic [1:0] p);
        csr_valid = 1'b1;
        csr_op = op;
        csr_addr = a;
        rs1_data = r;
        zimm = z;
        rd_zero = rz;
        priv = p;
    endtask

    // Reference semantics of one CSR instruction.
    function automatic logic [31:0] ref_new(input logic [2:0] op, input logic [31:0] old,
                                            input logic [31:0] r, input logic [4:0] z);
        logic [31:0] src;
        src = (op >= 3'd5) ? 32'(z) : r;
        if (op == 3'd1 || op == 3'd5) return src;
        if (op == 3'd2 || op == 3'd6) return old | src;
        return old & ~src;
    endfunction

    function automatic logic ref_writes(input logic [2:0] op, input logic [4:0] z);
        return (op == 3'd1 || op == 3'd5) || (z != 5'd0);
    endfunction

    function automatic logic ref_illegal(input logic [2:0] op, input logic [11:0] a,
                                         input logic [4:0] z, input logic [1:0] p);
        int need;
        need = int'(a[9:8]);
        if (need > int'(p)) return 1'b1;
        return ref_writes(op, z) && (a[11:10] == 2'b11);
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  z;
        logic        rdz;
        logic [1:0]  pv;
        logic [31:0] init;
        logic        e_we;
        logic [31:0] e_wb;
        logic [31:0] e_rd;
        logic        e_rdv;
        logic        e_ill;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] op, input logic [11:0] a, input logic [31:0] r,
                                input logic [4:0] z, input logic rz, input logic [1:0] p,
                                input logic [31:0] init, input logic we, input logic [31:0] wb,
                                input logic [31:0] rd, input logic rdv, input logic ill);
        vec_t v;
        v.op = op; v.addr = a; v.rs1 = r; v.z = z; v.rdz = rz; v.pv = p; v.init = init;
        v.e_we = we; v.e_wb = wb; v.e_rd = rd; v.e_rdv = rdv; v.e_ill = ill;
        return v;
    endfunction

    vec_t vt [10];
    logic [11:0] addrs [6];
    logic [2:0]  ops [6];
    logic [1:0]  privs [3];

    initial begin
        int pulses;
        int pulse_at;
        logic        p_we, p_rdv, p_ill;
        logic [11:0] p_addr;
        logic [31:0] p_wb, p_rd;

        vt[0] = mk(3'd1, 12'h340, 32'hDEADBEEF, 5'd1, 1'b0, 2'b11, 32'h12345678, 1'b1, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0);
        vt[1] = mk(3'd1, 12'hF11, 32'd5, 5'd1, 1'b0, 2'b11, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        vt[2] = mk(3'd2, 12'hF11, 32'h0, 5'd0, 1'b0, 2'b11, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        vt[3] = mk(3'd2, 12'h300, 32'h0, 5'd0, 1'b0, 2'b00, 32'h1800, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        vt[4] = mk(3'd2, 12'h300, 32'h0, 5'd0, 1'b0, 2'b11, 32'h1800, 1'b0, 32'h0, 32'h1800, 1'b1, 1'b0);
        vt[5] = mk(3'd7, 12'h340, 32'h0, 5'h0C, 1'b1, 2'b11, 32'hFF, 1'b1, 32'hF3, 32'h0, 1'b0, 1'b0);
        vt[6] = mk(3'd6, 12'h141, 32'h0, 5'd3, 1'b0, 2'b01, 32'h10, 1'b1, 32'h13, 32'h10, 1'b1, 1'b0);
        vt[7] = mk(3'd5, 12'h141, 32'h0, 5'd3, 1'b0, 2'b00, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        vt[8] = mk(3'd2, 12'hC00, 32'h0, 5'd0, 1'b0, 2'b00, 32'hABC, 1'b0, 32'h0, 32'hABC, 1'b1, 1'b0);
        vt[9] = mk(3'd2, 12'hC00, 32'h1, 5'd2, 1'b0, 2'b00, 32'hABC, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        addrs = '{12'h340, 12'h341, 12'hF11, 12'h300, 12'h141, 12'hC00};
        ops   = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        privs = '{2'b00, 2'b01, 2'b11};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_we", 32'(bus.csr_we), 32'd0);
        chk("rst_rdv", 32'(rd_valid), 32'd0);
        chk("rst_ill", 32'(illegal), 32'd0);
        chk("rst_awb", 32'(bus.csr_address_wb), 32'd0);
        chk("rst_wb", bus.csr_wb, 32'd0);
        chk("rst_rd", rd_data, 32'd0);
        nrst = 1'b1;

        // Single-instruction vectors
        for (int i = 0; i < 10; i++) begin
            preset(vt[i].addr, vt[i].init);
            drive(vt[i].op, vt[i].addr, vt[i].rs1, vt[i].z, vt[i].rdz, vt[i].pv);
            #1;
            chk($sformatf("v%0d_sreq", i), 32'(stall_req), 32'd0);
            @(negedge clk);
            csr_valid = 1'b0;
            chk($sformatf("v%0d_we", i), 32'(bus.csr_we), 32'(vt[i].e_we));
            chk($sformatf("v%0d_rdv", i), 32'(rd_valid), 32'(vt[i].e_rdv));
            chk($sformatf("v%0d_ill", i), 32'(illegal), 32'(vt[i].e_ill));
            if (vt[i].e_we) begin
                chk($sformatf("v%0d_awb", i), 32'(bus.csr_address_wb), 32'(vt[i].addr));
                chk($sformatf("v%0d_wb", i), bus.csr_wb, vt[i].e_wb);
            end
            if (vt[i].e_rdv) chk($sformatf("v%0d_rd", i), rd_data, vt[i].e_rd);
            @(negedge clk);
            chk($sformatf("v%0d_once", i), 32'(bus.csr_we), 32'd0);
        end

        // Back-to-back CSRRS / CSRRC on the same CSR
        preset(12'h340, 32'h100);
        drive(3'd2, 12'h340, 32'h0F, 5'd4, 1'b0, 2'b11);
        #1 chk("b2b_sreq0", 32'(stall_req), 32'd0);
        @(negedge clk);
        chk("b2b_we1", 32'(bus.csr_we), 32'd1);
        chk("b2b_wb1", bus.csr_wb, 32'h10F);
        chk("b2b_rd1", rd_data, 32'h100);
        drive(3'd3, 12'h340, 32'h03, 5'd5, 1'b0, 2'b11);
        #1 chk("b2b_sreq1", 32'(stall_req), FWD ? 32'd0 : 32'd1);
        if (!FWD) begin
            @(negedge clk);
            chk("b2b_bubble", 32'(bus.csr_we), 32'd0);
            chk("b2b_sreq2", 32'(stall_req), 32'd0);
        end
        @(negedge clk);
        csr_valid = 1'b0;
        chk("b2b_we2", 32'(bus.csr_we), 32'd1);
        chk("b2b_wb2", bus.csr_wb, 32'h10C);
        chk("b2b_rd2", rd_data, 32'h10F);
        @(negedge clk);
        chk("b2b_final", rf_mem[12'h340], 32'h10C);
        mref[12'h340] = 32'h10C;

        // CSRRWI held by stall for three cycles: one pulse, the cycle after stall drops
        drive(3'd5, 12'h340, 32'h0, 5'd7, 1'b0, 2'b11);
        stall = 1'b1;
        pulses = 0;
        pulse_at = -1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 3) stall = 1'b0;
            if (c == 4) csr_valid = 1'b0;
            if (bus.csr_we) begin
                pulses++;
                pulse_at = c;
            end
        end
        chk("stall_pulses", 32'(pulses), 32'd1);
        chk("stall_when", 32'(pulse_at), 32'd4);
        chk("stall_val", rf_mem[12'h340], 32'd7);

        // Same op killed by flush: no pulse
        drive(3'd5, 12'h340, 32'h0, 5'd9, 1'b0, 2'b11);
        flush = 1'b1;
        stall = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 3) begin
                csr_valid = 1'b0;
                flush = 1'b0;
                stall = 1'b0;
            end
            if (bus.csr_we || rd_valid) pulses++;
        end
        chk("flush_pulses", 32'(pulses), 32'd0);
        chk("flush_val", rf_mem[12'h340], 32'd7);
        mref[12'h340] = 32'd7;

        // Randomised instruction stream against the architectural model
        foreach (addrs[k]) preset(addrs[k], $urandom);
        p_we = 1'b0; p_rdv = 1'b0; p_ill = 1'b0;
        p_addr = 12'd0; p_wb = 32'd0; p_rd = 32'd0;
        for (int n = 0; n < 600; n++) begin
            logic        acc, exp_sr, ill, wr;
            logic [31:0] oldv, newv;
            @(negedge clk);
            chk("rnd_we", 32'(bus.csr_we), 32'(p_we));
            chk("rnd_rdv", 32'(rd_valid), 32'(p_rdv));
            chk("rnd_ill", 32'(illegal), 32'(p_ill));
            if (p_we) begin
                chk("rnd_awb", 32'(bus.csr_address_wb), 32'(p_addr));
                chk("rnd_wb", bus.csr_wb, p_wb);
            end
            if (p_rdv) chk("rnd_rd", rd_data, p_rd);
            drive(ops[$urandom_range(0, 5)], addrs[$urandom_range(0, 5)], $urandom,
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  ($urandom_range(0, 3) == 0), privs[$urandom_range(0, 2)]);
            csr_valid = ($urandom_range(0, 4) != 0);
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            #1;
            exp_sr = !FWD && csr_valid && p_we && (p_addr == csr_addr);
            chk("rnd_sreq", 32'(stall_req), 32'(exp_sr));
            acc = csr_valid && !stall && !flush && !exp_sr;
            oldv = mref[csr_addr];
            newv = ref_new(csr_op, oldv, rs1_data, zimm);
            wr = ref_writes(csr_op, zimm);
            ill = ref_illegal(csr_op, csr_addr, zimm, priv);
            p_we = acc && wr && !ill;
            p_rdv = acc && !ill && !rd_zero;
            p_ill = acc && ill;
            if (acc) begin
                p_addr = csr_addr;
                p_wb = newv;
                p_rd = oldv;
            end
            if (p_we) mref[csr_addr] = newv;
        end
        @(negedge clk);
        csr_valid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        chk("rnd_we_last", 32'(bus.csr_we), 32'(p_we));
        @(negedge clk);
        foreach (addrs[k]) chk($sformatf("rnd_mem_%h", addrs[k]), rf_mem[addrs[k]], mref[addrs[k]]);

        // Reset asserted during the WB cycle of a CSRRW
        drive(3'd1, 12'h341, 32'h5555AAAA, 5'd1, 1'b0, 2'b11);
        @(negedge clk);
        csr_valid = 1'b0;
        chk("rstwb_we_pre", 32'(bus.csr_we), 32'd1);
        nrst = 1'b0;
        @(negedge clk);
        chk("rstwb_we", 32'(bus.csr_we), 32'd0);
        chk("rstwb_rdv", 32'(rd_valid), 32'd0);
        chk("rstwb_ill", 32'(illegal), 32'd0);
        chk("rstwb_awb", 32'(bus.csr_address_wb), 32'd0);
        chk("rstwb_wb", bus.csr_wb, 32'd0);
        chk("rstwb_rd", rd_data, 32'd0);
        nrst = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/csr_unit.md
# csr_unit

Execute/write-back sequencer for Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms); it is the initiator side of the CSR register file's read/write port. In EX it drives the combinational read address, merges the old CSR value with the operand, and checks privilege and read-only violations. In WB it issues a single-cycle write strobe and returns the old value for rd. A WB→EX bypass covers back-to-back accesses to the same CSR.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  clock; all state on rising edge
- nrst  in  1  reset, synchronous, active-low
- csr_valid  in  1  CSR instruction present in EX
- csr_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 never asserted with csr_valid
- csr_addr  in  12  CSR address from instruction
- rs1_data  in  32  rs1 operand
- zimm  in  5  immediate / rs1 index
- rd_zero  in  1  rd == x0
- priv  in  2  current mode (U=00, S=01, M=11)
- stall  in  1  hold EX (no capture this cycle)
- flush  in  1  kill EX instruction this cycle
- csr_data  in  32  read data from register file (combinational on csr_address_r)
- csr_address_r  out  12  = csr_addr (combinational)
- csr_we  out  1  write strobe, WB stage
- csr_address_wb  out  12  write address, WB stage
- csr_wb  out  32  write data, WB stage
- rd_data  out  32  old CSR value for rd, WB stage
- rd_valid  out  1  rd write-back request
- illegal  out  1  illegal-instruction pulse (cause 2), WB stage
- stall_req  out  1  hazard stall request (combinational, EX)

## Operation
- Old value: csr_data, or csr_wb when forwarding hits (WB csr_we=1 and csr_address_wb == csr_addr).
- Operand: rs1_data for op[2]=0, zero-extended zimm for op[2]=1.
- New value: RW → operand; RS → old | operand; RC → old & ~operand.
- Write intent: RW/RWI always; RS/RC/RSI/RCI only when zimm != 0 (the rs1 index or immediate).
- Illegal when csr_addr[9:8] > priv, or when write intent and csr_addr[11:10] == 2'b11. An illegal op has csr_we=0, rd_valid=0, illegal=1.
- rd_valid = legal & !rd_zero. Reads happen regardless; the register file has no read side effects.
- WB register captures EX when csr_valid & !stall & !flush & !stall_req; otherwise it loads a bubble (csr_we, rd_valid, illegal = 0).
- Each instruction yields exactly one csr_we/illegal pulse, never repeated under stall.
- The register file drops writes while its exception_pending is high. Flushing of the WB stage is the trap logic's job, not this block's.

## Timing
- Reset (nrst=0 at an edge): csr_we=0, rd_valid=0, illegal=0, csr_address_wb=0, csr_wb=0, rd_data=0. Reset mid-instruction discards the instruction.
- Latency: EX in cycle n → WB outputs in cycle n+1 → register file commits at the edge ending n+1.
- Back-to-back same address: the EX op in n+1 sees the WB value of n via the bypass. There are zero bubbles with forwarding enabled.
- Different addresses never conflict. stall_req is 0 whenever WB is a bubble.
- stall and flush together: flush wins (bubble).

## Configuration
- CSR_FWD_EN defined: bypass active; stall_req is tied 0.
- Undefined: no bypass. On a same-address hazard, stall_req=1 for one cycle, EX is not captured, and the op is captured the following cycle once WB is a bubble. This costs a 1-cycle penalty per hazard.

## Test plan
- M-mode CSRRW 0x340 (mscratch), rs1=0xDEADBEEF, register file returns 0x12345678 → next cycle csr_we=1, csr_address_wb=0x340, csr_wb=0xDEADBEEF, rd_data=0x12345678, rd_valid=1.
- CSRRS 0x340 rs1=0x0F immediately followed by CSRRC 0x340 rs1=0x03, initial 0x100 → writes 0x10F then 0x10C. With CSR_FWD_EN: stall_req=0 throughout. Without: one stall_req cycle and the same final values.
- CSRRW 0xF11 rs1=5 → illegal=1, csr_we=0. CSRRS 0xF11 zimm=0 → legal, rd_data=0, no write.
- priv=U, CSRRS 0x300 zimm=0 → illegal=1, rd_valid=0. Same op at priv=M → legal.
- CSRRWI 0x340 zimm=7 with stall=1 for 3 cycles then 0 → exactly one csr_we pulse, in the cycle after stall drops. With flush=1 instead → no pulse.
- Assert nrst=0 during the WB cycle of a CSRRW → csr_we=0 after the edge and all outputs at reset values.
